wb_scoreboard: RTL and testbench

- Producer-side tracker for the register-forwarding network.
- Records every destination register at issue from decode, ages it through the pipeline, and reports per-operand pending/ready status.
- Retires entries at writeback.
- Feeds decode-stage hazard logic: tells decode whether a source operand is in flight and whether the forwarding network can already supply it.
- Also flags write-after-write conflicts.

---
 rtl/wb_scoreboard.sv | 136 +++++++++++++
 tb/tb_wb_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// Destination-register scoreboard: tracks in-flight producers from issue to writeback
// and tells decode whether each source operand is pending and already forwardable.
module wb_scoreboard #(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 5,
  parameter int CNT_W   = 3
) (
  input  logic       clk_i,
  input  logic       rsn_i,
  input  logic       issue_en_i,
  input  logic [4:0] issue_addr_i,
  input  logic [1:0] issue_kind_i,
  input  logic [4:0] read_addr_a_i,
  input  logic [4:0] read_addr_b_i,
  input  logic       load_done_i,
  input  logic [4:0] load_done_addr_i,
  input  logic       wb_en_i,
  input  logic [4:0] wb_addr_i,
  input  logic       flush_i,
  output logic       pending_a_o,
  output logic       pending_b_o,
  output logic       ready_a_o,
  output logic       ready_b_o,
  output logic       stall_o,
  output logic [4:0] inflight_cnt_o
);

  localparam logic [1:0] KIND_ALU  = 2'b00;
  localparam logic [1:0] KIND_MUL  = 2'b01;
  localparam logic [1:0] KIND_LOAD = 2'b10;

  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);

  // Bit 0 of valid_q/rdy_q stays 0 so register 0 always reads as not pending.
  logic [31:0]      valid_q;
  logic [31:0]      rdy_q;
  logic [1:0]       kind_q [1:31];
  logic [CNT_W-1:0] cnt_q  [1:31];
  logic [4:0]       inflight_q;

  logic             issue_accept;
  logic             issue_new;
  logic             retire_hit;
  logic [1:0]       issue_kind;
  logic [CNT_W-1:0] issue_cnt;
  logic             issue_rdy;
  logic [4:0]       inflight_next;

  // Issue handshake: issue_en_i is valid, !stall_o is ready; an instruction transfers
  // only in a cycle where both are high, otherwise decode holds and re-presents it.
  always_comb begin
    pending_a_o = valid_q[read_addr_a_i];
    pending_b_o = valid_q[read_addr_b_i];
    ready_a_o   = valid_q[read_addr_a_i] && rdy_q[read_addr_a_i];
    ready_b_o   = valid_q[read_addr_b_i] && rdy_q[read_addr_b_i];
    stall_o     = (pending_a_o && !ready_a_o) ||
                  (pending_b_o && !ready_b_o) ||
                  (issue_en_i && valid_q[issue_addr_i]);
    inflight_cnt_o = inflight_q;
  end

  // The reserved kind encoding is tracked exactly like an ALU producer.
  always_comb begin
    issue_kind = KIND_ALU;
    issue_cnt  = ALU_CNT;
    case (issue_kind_i)
      KIND_MUL: begin
        issue_kind = KIND_MUL;
        issue_cnt  = MUL_CNT;
      end
      KIND_LOAD: begin
        issue_kind = KIND_LOAD;
        issue_cnt  = '0;
      end
      default: begin
        issue_kind = KIND_ALU;
        issue_cnt  = ALU_CNT;
      end
    endcase
    issue_rdy = (issue_kind != KIND_LOAD) && (issue_cnt == '0);
  end

  always_comb begin
    issue_accept = issue_en_i && !stall_o && (issue_addr_i != 5'd0);
    issue_new    = issue_accept && !valid_q[issue_addr_i];
    // A writeback to the register being re-issued this cycle is absorbed by the issue.
    retire_hit   = wb_en_i && (wb_addr_i != 5'd0) && valid_q[wb_addr_i] &&
                   !(issue_accept && (issue_addr_i == wb_addr_i));
    inflight_next = inflight_q;
    case ({issue_new, retire_hit})
      2'b10:   inflight_next = inflight_q + 5'd1;
      2'b01:   inflight_next = inflight_q - 5'd1;
      default: inflight_next = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i || flush_i) begin
      valid_q    <= '0;
      rdy_q      <= '0;
      inflight_q <= '0;
      for (int r = 1; r < 32; r++) begin
        kind_q[r] <= KIND_ALU;
        cnt_q[r]  <= '0;
      end
    end else begin
      inflight_q <= inflight_next;
      for (int r = 1; r < 32; r++) begin
        if (issue_accept && (issue_addr_i == 5'(r))) begin
          valid_q[r] <= 1'b1;
          rdy_q[r]   <= issue_rdy;
          kind_q[r]  <= issue_kind;
          cnt_q[r]   <= issue_cnt;
        end else if (wb_en_i && (wb_addr_i == 5'(r))) begin
          valid_q[r] <= 1'b0;
          rdy_q[r]   <= 1'b0;
          cnt_q[r]   <= '0;
        end else if (valid_q[r]) begin
          // Loads become ready on their cache return; ALU/MUL age down to zero.
          if (kind_q[r] == KIND_LOAD) begin
            if (load_done_i && (load_done_addr_i == 5'(r))) begin
              rdy_q[r] <= 1'b1;
            end
          end else if (cnt_q[r] != '0) begin
            cnt_q[r] <= cnt_q[r] - 1'b1;
            if (cnt_q[r] == CNT_W'(1)) begin
              rdy_q[r] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: each step queues the expected operand status and
// pops it against the DUT outputs once they have settled.
module tb_wb_scoreboard;

  logic       clk = 1'b0;
  logic       rsn;
  logic       issue_en;
  logic [4:0] issue_addr;
  logic [1:0] issue_kind;
  logic [4:0] read_addr_a;
  logic [4:0] read_addr_b;
  logic       load_done;
  logic [4:0] load_done_addr;
  logic       wb_en;
  logic [4:0] wb_addr;
  logic       flush;
  logic       pending_a;
  logic       pending_b;
  logic       ready_a;
  logic       ready_b;
  logic       stall;
  logic [4:0] inflight_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  wb_scoreboard #(.ALU_LAT(1), .MUL_LAT(5), .CNT_W(3)) dut (
    .clk_i            (clk),
    .rsn_i            (rsn),
    .issue_en_i       (issue_en),
    .issue_addr_i     (issue_addr),
    .issue_kind_i     (issue_kind),
    .read_addr_a_i    (read_addr_a),
    .read_addr_b_i    (read_addr_b),
    .load_done_i      (load_done),
    .load_done_addr_i (load_done_addr),
    .wb_en_i          (wb_en),
    .wb_addr_i        (wb_addr),
    .flush_i          (flush),
    .pending_a_o      (pending_a),
    .pending_b_o      (pending_b),
    .ready_a_o        (ready_a),
    .ready_b_o        (ready_b),
    .stall_o          (stall),
    .inflight_cnt_o   (inflight_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic pa, input logic ra,
                            input logic pb, input logic rb, input logic st,
                            input logic [4:0] cnt);
    exp_q.push_back({pa, ra, pb, rb, st, cnt});
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    logic [9:0] e;
    logic [9:0] o;
    string      t;
    #2;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {pending_a, ready_a, pending_b, ready_b, stall, inflight_cnt};
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed pa/ra/pb/rb/stall/cnt=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
                t, o[9], o[8], o[7], o[6], o[5], o[4:0], e[9], e[8], e[7], e[6], e[5], e[4:0]);
  endtask

  task automatic chk(input string tag, input logic pa, input logic ra, input logic pb,
                     input logic rb, input logic st, input logic [4:0] cnt);
    expect_out(tag, pa, ra, pb, rb, st, cnt);
    compare_out();
  endtask

  task automatic issue(input logic [4:0] addr, input logic [1:0] kind);
    issue_en   = 1'b1;
    issue_addr = addr;
    issue_kind = kind;
  endtask

  task automatic retire(input logic [4:0] addr);
    wb_en   = 1'b1;
    wb_addr = addr;
    tick();
    wb_en   = 1'b0;
  endtask

  initial begin
    rsn = 1'b0; flush = 1'b0; load_done = 1'b0; load_done_addr = '0;
    wb_en = 1'b0; wb_addr = '0; read_addr_a = 5'd5; read_addr_b = '0;
    issue(5'd5, 2'b00);
    repeat (3) tick();
    rsn = 1'b1;
    issue_en = 1'b0;
    chk("reset", 0, 0, 0, 0, 0, 5'd0);

    // ALU producer: visible in cycle 0, forwardable from cycle 1
    read_addr_a = '0;
    issue(5'd3, 2'b00);
    chk("alu_pre", 0, 0, 0, 0, 0, 5'd0);
    tick(); issue_en = 1'b0; read_addr_a = 5'd3;
    chk("alu_c0", 1, 0, 0, 0, 1, 5'd1);
    tick(); chk("alu_c1", 1, 1, 0, 0, 0, 5'd1);
    tick(); chk("alu_c2", 1, 1, 0, 0, 0, 5'd1);
    tick(); wb_en = 1'b1; wb_addr = 5'd3;
    chk("alu_c3_wb", 1, 1, 0, 0, 0, 5'd1);
    tick(); wb_en = 1'b0;
    chk("alu_c4_retired", 0, 0, 0, 0, 0, 5'd0);

    // MUL producer: stalls through cycle 4, forwardable at cycle 5
    read_addr_a = '0;
    issue(5'd7, 2'b01);
    tick(); issue_en = 1'b0; read_addr_b = 5'd7;
    chk("mul_c0", 0, 0, 1, 0, 1, 5'd1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("mul_c%0d", c), 0, 0, 1, 0, 1, 5'd1);
    end
    tick(); chk("mul_c5", 0, 0, 1, 1, 0, 5'd1);
    retire(5'd7);
    chk("mul_retired", 0, 0, 0, 0, 0, 5'd0);

    // LOAD producer: ready only after its own load_done, stray return ignored
    read_addr_b = '0;
    issue(5'd9, 2'b10);
    tick(); issue_en = 1'b0; read_addr_a = 5'd9; read_addr_b = 5'd10;
    chk("load_c0", 1, 0, 0, 0, 1, 5'd1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      load_done = 1'b0;
      chk($sformatf("load_c%0d", c), 1, 0, 0, 0, 1, 5'd1);
      if (c == 2) begin
        load_done = 1'b1; load_done_addr = 5'd10;
      end else if (c == 6) begin
        load_done = 1'b1; load_done_addr = 5'd9;
      end
    end
    tick(); load_done = 1'b0;
    chk("load_c7", 1, 1, 0, 0, 0, 5'd1);
    retire(5'd9);
    chk("load_retired", 1'b0, 0, 0, 0, 0, 5'd0);

    // Reserved kind behaves as ALU
    read_addr_a = '0; read_addr_b = '0;
    issue(5'd12, 2'b11);
    tick(); issue_en = 1'b0; read_addr_a = 5'd12;
    chk("rsv_c0", 1, 0, 0, 0, 1, 5'd1);
    tick(); chk("rsv_c1", 1, 1, 0, 0, 0, 5'd1);
    retire(5'd12);
    chk("rsv_retired", 0, 0, 0, 0, 0, 5'd0);

    // WAW: re-issue of a pending register stalls and is dropped
    read_addr_a = '0;
    issue(5'd4, 2'b00);
    tick(); issue(5'd4, 2'b01);
    chk("waw_stall", 0, 0, 0, 0, 1, 5'd1);
    tick(); issue_en = 1'b0; read_addr_a = 5'd4;
    chk("waw_unchanged", 1, 1, 0, 0, 0, 5'd1);
    retire(5'd4);
    read_addr_a = '0;
    chk("waw_retired", 0, 0, 0, 0, 0, 5'd0);

    // Register 0 is never tracked
    issue(5'd0, 2'b01);
    tick(); issue_en = 1'b0;
    chk("x0_issue", 0, 0, 0, 0, 0, 5'd0);

    // Same-cycle issue and writeback on x8: the issue becomes the producer
    issue(5'd8, 2'b00);
    wb_en = 1'b1; wb_addr = 5'd8;
    chk("coll_pre", 0, 0, 0, 0, 0, 5'd0);
    tick(); issue_en = 1'b0; wb_en = 1'b0; read_addr_a = 5'd8;
    chk("coll_c0", 1, 0, 0, 0, 1, 5'd1);
    tick(); chk("coll_c1", 1, 1, 0, 0, 0, 5'd1);

    // Issue x11 while x8 retires: population count nets to zero
    read_addr_a = '0;
    issue(5'd11, 2'b00);
    wb_en = 1'b1; wb_addr = 5'd8;
    chk("net0_pre", 0, 0, 0, 0, 0, 5'd1);
    tick(); issue_en = 1'b0; wb_en = 1'b0; read_addr_a = 5'd8; read_addr_b = 5'd11;
    chk("net0_c0", 0, 0, 1, 0, 1, 5'd1);
    tick(); chk("net0_c1", 0, 0, 1, 1, 0, 5'd1);
    retire(5'd11);
    read_addr_a = '0; read_addr_b = '0;
    chk("net0_retired", 0, 0, 0, 0, 0, 5'd0);

    // Flush with a MUL (cnt=3) and a LOAD in flight
    issue(5'd2, 2'b01);
    tick(); issue(5'd6, 2'b10);
    tick(); issue_en = 1'b0;
    tick(); read_addr_a = 5'd2; read_addr_b = 5'd6;
    chk("flush_pre", 1, 0, 1, 0, 1, 5'd2);
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_c0", 0, 0, 0, 0, 0, 5'd0);
    load_done = 1'b1; load_done_addr = 5'd6;
    tick(); load_done = 1'b0;
    chk("flush_ld_ignored", 0, 0, 0, 0, 0, 5'd0);
    repeat (4) tick();
    chk("flush_late", 0, 0, 0, 0, 0, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
